rst_seq_ctrl: RTL
=================

# rst_seq_ctrl

Parametrised reset sequencer and CPU clock-enable controller. It sits between the board-level `clk`/`rst` and the `cpu` instance plus its memories and peripherals. It holds every downstream block in reset for a programmable time, then releases `NUM_CH` reset channels in a fixed, staggered order. Once sequencing completes, it gates CPU progress through a clock enable with run, single-step and halt modes. It also supports a soft-reset request that replays the whole sequence.

## Interface
- `NUM_CH`, 4: number of reset output channels; channel 0 is released first. Range ≥ 1.
- `HOLD_CYCLES`, 16: cycles all channels stay in reset after reset is removed. Range ≥ 1.
- `STAGGER`, 4: cycles between consecutive channel releases. Range ≥ 1.
- `DIV_W`, 8: width of the clock-enable divider ratio.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `soft_rst_req` in 1: request to replay the reset sequence; level-sensitive.
- `mode` in 2: 00 = run, 01 = step, 10 or 11 = halt.
- `step_req` in 1: step request, sampled each cycle in step mode.
- `div` in DIV_W: in run mode, `ce` fires every `div+1` cycles.
- `rst_out` out NUM_CH: per-channel active-high reset.
- `ce` out 1: CPU clock enable; registered.
- `seq_done` out 1: high once all channels are released.
- `state` out 2: 00 = HOLD, 01 = RELEASE, 10 = RUN.
- `soft_rst_seen` out 1: sticky flag; set by a soft reset, cleared only by `rst`.

## Operation
- **Reset values** (applied at any edge with `rst=1`):
  - `rst_out` = all ones, `ce=0`, `seq_done=0`, `state=HOLD`, `soft_rst_seen=0`.
  - Hold counter, stagger counter, channel index and divider counter all cleared.
- **Soft reset.** An edge with `soft_rst_req=1` has the same effect as `rst`, in any state, with these differences:
  - `soft_rst_seen` is set to 1 instead of cleared.
  - If `rst` and `soft_rst_req` are both high, `rst` wins and `soft_rst_seen` ends at 0.
- **HOLD**
  - The hold counter increments on each edge where neither reset source is high.
  - When it reaches `HOLD_CYCLES`, the block clears `rst_out[0]` and moves to RELEASE on that same edge.
  - If `NUM_CH=1`, it moves straight to RUN instead.
- **RELEASE**
  - Every `STAGGER` edges, the block clears the next `rst_out[i]`.
  - On the edge that clears `rst_out[NUM_CH-1]`, it sets `seq_done=1`, moves to RUN, and clears the divider counter.
  - A channel, once released, stays released until the next reset source.
- **RUN, mode run** (divider counter `cnt` is internal, width DIV_W):
  - Each edge: if `cnt >= div`, then `ce<=1` and `cnt<=0`.
  - Otherwise `ce<=0` and `cnt<=cnt+1`.
  - `div=0` gives `ce` held high.
  - If `div` changes mid-count, the `>=` compare applies immediately, with no stall.
- **RUN, mode step:** `ce<=step_req` each edge; `cnt` is held at 0.
- **RUN, mode halt:** `ce<=0`; `cnt` is held at 0.
- **Outside RUN:** `ce` is forced to 0 and `step_req`, `mode` and `div` are ignored.
- **Mode changes** take effect on the next edge. `cnt` is cleared whenever mode ≠ run.

## Timing
- Edge t=1 is the first edge sampling `rst=0` and `soft_rst_req=0`.
- `rst_out[i]` falls at edge `HOLD_CYCLES + i*STAGGER`.
- `seq_done` rises with `rst_out[NUM_CH-1]`. With defaults, releases occur at edges 16, 20, 24 and 28.
- In run mode, the first `ce` pulse occurs at the `seq_done` edge + `div+1`; subsequent pulses follow every `div+1` edges.
- Step mode: `step_req` sampled at edge E gives `ce` high for the cycle after E. Back-to-back requests give consecutive `ce` cycles.
- A reset source takes effect at the sampling edge with zero latency:
  - All channels reassert at that edge, including mid-RELEASE and mid-divider count.
  - Holding a reset source high keeps the block in HOLD with the counter at 0.

## Test plan
- **Power-on sequence.** `rst` high for 3 edges, then low, defaults:
  - `rst_out` goes 1110 at t=16, 1100 at 20, 1000 at 24, 0000 at 28.
  - `seq_done=1` and `state=10` at t=28.
  - `ce=0` throughout.
- **Divider.** `mode=00`, `div=2`: `ce` high only after edges 31, 34, 37, …. Then `div=0`: `ce` high every cycle.
- **Step and halt.**
  - `mode=01`, `step_req` sampled high at edges 40, 41, 45: `ce` high only after those edges.
  - `mode=10` with `step_req` held high: `ce` stays 0.
- **Soft reset from RUN.** `soft_rst_req` sampled high at edge 50:
  - At edge 50: `rst_out=1111`, `ce=0`, `seq_done=0`, `soft_rst_seen=1`.
  - Releases at edges 66, 70, 74, 78.
  - `soft_rst_seen` stays 1 after `seq_done` rises again.
- **Reset mid-release.** `rst` asserted at edge 22 (`rst_out=1100`):
  - At edge 22: `rst_out=1111`, `soft_rst_seen=0`.
  - The sequence restarts from t=1 after `rst` falls.
  - `rst` and `soft_rst_req` both high gives `soft_rst_seen=0`.
- **Divider change mid-count.** `div=5`, then `div=1` written while `cnt=3`:
  - `ce` high on the next edge.
  - Then high every 2 edges.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl
//
// Reset sequencer and CPU clock-enable controller. After reset is removed,
// every downstream channel stays in reset for HOLD_CYCLES edges. The channels
// are then released one at a time, channel 0 first, with STAGGER edges
// between releases. Once the last channel is released, the block enters RUN
// and drives a registered CPU clock enable (ce). The enable has three modes:
// run (divided by div+1), single-step and halt. A soft-reset request replays
// the whole sequence and sets a sticky flag that only rst clears.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous active-high reset
//   soft_rst_req   : level-sensitive request to replay the reset sequence
//   mode [1:0]     : 00 run, 01 step, 1x halt (only used in RUN)
//   step_req       : step request, sampled each edge in step mode
//   div [DIV_W-1:0]: in run mode, ce fires every div+1 edges
//   rst_out        : per-channel active-high reset
//   ce             : registered CPU clock enable
//   seq_done       : all channels released
//   state [1:0]    : 00 HOLD, 01 RELEASE, 10 RUN (also the FSM debug view)
//   soft_rst_seen  : sticky, set by a soft reset, cleared by rst
module rst_seq_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int DIV_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst_req,
  input  logic [1:0]        mode,
  input  logic              step_req,
  input  logic [DIV_W-1:0]  div,
  output logic [NUM_CH-1:0] rst_out,
  output logic              ce,
  output logic              seq_done,
  output logic [1:0]        state,
  output logic              soft_rst_seen
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STAG_W = $clog2(STAGGER + 1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_HOLD    = 2'b00;
  localparam logic [1:0] ST_RELEASE = 2'b01;
  localparam logic [1:0] ST_RUN     = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic              ce_q, ce_d;
  logic              seq_done_q, seq_done_d;
  logic              soft_seen_q, soft_seen_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [STAG_W-1:0] stag_cnt_q, stag_cnt_d;
  logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;

  // ch_idx_q holds the most recently released channel.
  logic [CH_W-1:0] ch_next;
  logic            ch_next_last;

  assign ch_next      = ch_idx_q + CH_W'(1);
  assign ch_next_last = (32'(ch_next) == NUM_CH - 1);

  always_comb begin
    state_d     = state_q;
    rst_out_d   = rst_out_q;
    ce_d        = 1'b0;
    seq_done_d  = seq_done_q;
    soft_seen_d = soft_seen_q;
    hold_cnt_d  = hold_cnt_q;
    stag_cnt_d  = stag_cnt_q;
    ch_idx_d    = ch_idx_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_HOLD: begin
        // The edge on which the count would reach HOLD_CYCLES releases channel 0.
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          rst_out_d[0] = 1'b0;
          hold_cnt_d   = '0;
          stag_cnt_d   = '0;
          ch_idx_d     = '0;
          if (NUM_CH == 1) begin
            seq_done_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_RELEASE: begin
        if (stag_cnt_q == STAG_W'(STAGGER - 1)) begin
          stag_cnt_d         = '0;
          ch_idx_d           = ch_next;
          rst_out_d[ch_next] = 1'b0;
          if (ch_next_last) begin
            seq_done_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_RUN;
          end
        end else begin
          stag_cnt_d = stag_cnt_q + STAG_W'(1);
        end
      end

      ST_RUN: begin
        case (mode)
          2'b00: begin
            // Compare against the live div so a reprogram acts immediately.
            if (cnt_q >= div) begin
              ce_d  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + DIV_W'(1);
            end
          end
          2'b01: begin
            ce_d  = step_req;
            cnt_d = '0;
          end
          default: begin
            cnt_d = '0;
          end
        endcase
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // Soft reset replays everything; rst (in the flop block) overrides it.
    if (soft_rst_req) begin
      state_d     = ST_HOLD;
      rst_out_d   = '1;
      ce_d        = 1'b0;
      seq_done_d  = 1'b0;
      soft_seen_d = 1'b1;
      hold_cnt_d  = '0;
      stag_cnt_d  = '0;
      ch_idx_d    = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      rst_out_q   <= '1;
      ce_q        <= 1'b0;
      seq_done_q  <= 1'b0;
      soft_seen_q <= 1'b0;
      hold_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      ch_idx_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rst_out_q   <= rst_out_d;
      ce_q        <= ce_d;
      seq_done_q  <= seq_done_d;
      soft_seen_q <= soft_seen_d;
      hold_cnt_q  <= hold_cnt_d;
      stag_cnt_q  <= stag_cnt_d;
      ch_idx_q    <= ch_idx_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rst_out       = rst_out_q;
  assign ce            = ce_q;
  assign seq_done      = seq_done_q;
  assign state         = state_q;
  assign soft_rst_seen = soft_seen_q;

endmodule
